// File: rtl/vca.sv
// vca: envelope-controlled amplifier using a sequential shift-add multiplier.
// Optional envelope smoothing is enabled by defining VCA_ENV_SMOOTH_EN.
module vca #(
  parameter int SAMPLE_W = 16,
  parameter int ENV_W    = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       low_clk,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic        [ENV_W-1:0]    env_in,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_valid,
  output logic                       busy,
  output logic                       overrun
);

  localparam int ACC_W = SAMPLE_W + ENV_W;
  localparam int CNT_W = $clog2(ENV_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ENV_W - 1);
  localparam logic signed [ACC_W-1:0] ROUND = ACC_W'(1) << (ENV_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t                     state_q, state_d;
  logic signed [ACC_W-1:0]    mcand_q, mcand_d;
  logic        [ENV_W-1:0]    mplier_q, mplier_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic        [CNT_W-1:0]    cnt_q, cnt_d;
  logic signed [SAMPLE_W-1:0] sample_out_q, sample_out_d;
  logic                       sample_valid_q, sample_valid_d;
  logic                       busy_q, busy_d;
  logic                       overrun_q, overrun_d;
  logic        [ENV_W-1:0]    env_eff;

`ifdef VCA_ENV_SMOOTH_EN
  logic        [ENV_W-1:0]    env_s_q, env_s_d;
  logic signed [ENV_W:0]      env_diff;
  logic        [ENV_W-1:0]    env_s_next;
`endif

  always_comb begin
    state_d        = state_q;
    mcand_d        = mcand_q;
    mplier_d       = mplier_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = 1'b0;
    overrun_d      = overrun_q;
    env_eff        = env_in;
`ifdef VCA_ENV_SMOOTH_EN
    // One-pole filter; the step is added modulo 2^ENV_W, which is exact because env_s stays in range.
    env_diff   = $signed({1'b0, env_in}) - $signed({1'b0, env_s_q});
    env_s_next = env_s_q + ENV_W'(env_diff >>> 4);
    env_s_d    = env_s_q;
    env_eff    = env_s_next;
`endif

    case (state_q)
      IDLE: begin
        if (low_clk) begin
          mcand_d  = {{ENV_W{sample_in[SAMPLE_W-1]}}, sample_in};
          mplier_d = env_eff;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = MUL;
`ifdef VCA_ENV_SMOOTH_EN
          env_s_d  = env_s_next;
`endif
        end
      end
      MUL: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        sample_out_d   = SAMPLE_W'((acc_q + ROUND) >>> ENV_W);
        sample_valid_d = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (low_clk && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end
    // busy also covers the valid-pulse cycle after DONE
    busy_d = (state_d != IDLE) || (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      mcand_q        <= '0;
      mplier_q       <= '0;
      acc_q          <= '0;
      cnt_q          <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
`ifdef VCA_ENV_SMOOTH_EN
      env_s_q        <= '0;
`endif
    end else begin
      state_q        <= state_d;
      mcand_q        <= mcand_d;
      mplier_q       <= mplier_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
`ifdef VCA_ENV_SMOOTH_EN
      env_s_q        <= env_s_d;
`endif
    end
  end

  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_vca.sv
// tb_vca: self-checking bench for vca; directed vectors, random vectors against
// an arithmetic reference model, and multi-cycle corner-case sequences.
module tb_vca;

  localparam int SAMPLE_W = 16;
  localparam int ENV_W    = 24;
  localparam int LATENCY  = ENV_W + 1;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic                       low_clk = 1'b0;
  logic signed [SAMPLE_W-1:0] sample_in = '0;
  logic        [ENV_W-1:0]    env_in = '0;
  logic signed [SAMPLE_W-1:0] sample_out;
  logic                       sample_valid;
  logic                       busy;
  logic                       overrun;

  int nChecks = 0;
  int nFails  = 0;

`ifdef VCA_ENV_SMOOTH_EN
  longint envModel = 0;
`endif

  typedef struct {
    int sample;
    int env;
    int expected;
  } vector_t;

  always #5 clk = ~clk;

  vca #(.SAMPLE_W(SAMPLE_W), .ENV_W(ENV_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .low_clk      (low_clk),
    .sample_in    (sample_in),
    .env_in       (env_in),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  // Reference: round-half-up of sample*env / 2^ENV_W, computed in 64-bit arithmetic.
  function automatic int refProduct(input int s, input longint e);
    longint p;
    p = longint'(s) * e + (longint'(1) <<< (ENV_W - 1));
    return int'(p >>> ENV_W);
  endfunction

  // Expected result of an accepted strobe; advances the smoothing model when enabled.
  function automatic int nextExpected(input int s, input int e);
`ifdef VCA_ENV_SMOOTH_EN
    envModel = envModel + ((longint'(e) - envModel) >>> 4);
    return refProduct(s, envModel);
`else
    return refProduct(s, longint'(e));
`endif
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drives a one-cycle strobe, then scrambles the inputs to prove they are latched.
  task automatic applyStimulus(input int s, input int e, output int expVal);
    @(negedge clk);
    sample_in = SAMPLE_W'(s);
    env_in    = ENV_W'(e);
    low_clk   = 1'b1;
    expVal    = nextExpected(s, e);
    @(negedge clk);
    low_clk   = 1'b0;
    sample_in = SAMPLE_W'($urandom);
    env_in    = ENV_W'($urandom);
    checkOutput("busy after strobe", longint'(busy), 1);
  endtask

  task automatic waitResult(input string name, input int expVal, input int startN);
    int n;
    n = startN;
    while (!sample_valid && n < 80) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " latency"}, n, LATENCY);
    checkOutput({name, " value"}, longint'(sample_out), expVal);
  endtask

  task automatic checkTail(input string name);
    @(negedge clk);
    checkOutput({name, " valid width"}, longint'(sample_valid), 0);
    checkOutput({name, " busy drop"}, longint'(busy), 0);
  endtask

  task automatic countValids(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (sample_valid) pulses++;
    end
  endtask

  task automatic pulseReset(input int cycles);
    rst = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b1;
`ifdef VCA_ENV_SMOOTH_EN
    envModel = 0;
`endif
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int expVal;
    int pulses;
    int busySeen;
    vector_t vecs[$];

    // Reset and idle hold
    @(negedge clk);
    pulseReset(4);
    checkOutput("reset sample_out", longint'(sample_out), 0);
    checkOutput("reset sample_valid", longint'(sample_valid), 0);
    checkOutput("reset busy", longint'(busy), 0);
    checkOutput("reset overrun", longint'(overrun), 0);
    busySeen = 0;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) busySeen++;
      if (sample_valid) pulses++;
    end
    checkOutput("idle busy cycles", busySeen, 0);
    checkOutput("idle valid pulses", pulses, 0);

`ifndef VCA_ENV_SMOOTH_EN
    vecs.push_back('{1000, 32'hFFFFFF, 1000});
    vecs.push_back('{1000, 0, 0});
    vecs.push_back('{1000, 32'h800000, 500});
    vecs.push_back('{-1000, 32'h800000, -500});
    vecs.push_back('{-32768, 32'hFFFFFF, -32768});
    vecs.push_back('{32767, 32'hFFFFFF, 32767});
    vecs.push_back('{1, 32'h800000, 1});
    vecs.push_back('{-1, 32'h800000, 0});
    vecs.push_back('{3, 32'h800000, 2});
    vecs.push_back('{-3, 32'h800000, -1});
    vecs.push_back('{-32768, 32'h400000, -8192});
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].sample, vecs[i].env, expVal);
      checkOutput($sformatf("vector %0d model", i), expVal, vecs[i].expected);
      waitResult($sformatf("vector %0d", i), vecs[i].expected, 0);
      checkTail($sformatf("vector %0d", i));
    end
`endif

    // Random vectors against the reference model
    for (int i = 0; i < 30; i++) begin
      int s;
      int e;
      s = int'($urandom_range(0, 65535)) - 32768;
      case ($urandom_range(0, 3))
        0:       e = 32'hFFFFFF;
        1:       e = 0;
        default: e = int'($urandom & 32'hFFFFFF);
      endcase
      applyStimulus(s, e, expVal);
      waitResult($sformatf("random %0d", i), expVal, 0);
      checkTail($sformatf("random %0d", i));
    end

    // Back-to-back: next strobe lands on the first edge it may be accepted
    applyStimulus(12345, 32'hC00000, expVal);
    waitResult("b2b first", expVal, 0);
    sample_in = -16'sd20000;
    env_in    = 24'hA00000;
    low_clk   = 1'b1;
    expVal    = nextExpected(-20000, 32'hA00000);
    @(negedge clk);
    low_clk = 1'b0;
    checkOutput("b2b no overrun", longint'(overrun), 0);
    checkOutput("b2b busy", longint'(busy), 1);
    waitResult("b2b second", expVal, 0);
    checkTail("b2b second");

    // Overrun: second strobe ten cycles into the multiply is dropped
    applyStimulus(-7777, 32'h9ABCDE, expVal);
    repeat (9) @(negedge clk);
    sample_in = 16'sd30000;
    env_in    = 24'hFFFFFF;
    low_clk   = 1'b1;
    @(negedge clk);
    low_clk = 1'b0;
    checkOutput("overrun set", longint'(overrun), 1);
    waitResult("overrun first", expVal, 10);
    checkTail("overrun first");
    countValids(60, pulses);
    checkOutput("overrun extra valid", pulses, 0);
    checkOutput("overrun sticky", longint'(overrun), 1);

    // Reset mid-multiply
    applyStimulus(20000, 32'hFFFFFF, expVal);
    repeat (11) @(negedge clk);
    pulseReset(1);
    checkOutput("midreset sample_out", longint'(sample_out), 0);
    checkOutput("midreset busy", longint'(busy), 0);
    checkOutput("midreset overrun", longint'(overrun), 0);
    countValids(40, pulses);
    checkOutput("midreset valid pulses", pulses, 0);
    applyStimulus(-4321, 32'h555555, expVal);
    waitResult("after reset", expVal, 0);
    checkTail("after reset");

`ifdef VCA_ENV_SMOOTH_EN
    // Envelope step 0 -> full scale through the smoother
    begin
      int prev;
      pulseReset(2);
      prev = 0;
      for (int i = 0; i < 200; i++) begin
        applyStimulus(16384, 32'hFFFFFF, expVal);
        if (i == 0) checkOutput("smooth first env", envModel, 32'h0FFFFF);
        if (i == 1) checkOutput("smooth second env", envModel, 32'h1EFFFF);
        waitResult($sformatf("smooth %0d", i), expVal, 0);
        if (sample_out < prev) checkOutput($sformatf("smooth monotonic %0d", i), longint'(sample_out), prev);
        prev = int'(sample_out);
        repeat (10) @(negedge clk);
      end
      checkOutput("smooth converged", longint'(sample_out), 16384);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/vca.md
# vca

Envelope-controlled amplifier stage: directly downstream of `adsr`. On each 48 kHz sample strobe it multiplies the current signed audio sample by the 24-bit unsigned envelope word from `adsr.signal_out`. A sequential shift-add multiplier computes the product. It then presents the rounded, scaled sample with a one-cycle valid pulse to the output/DAC stage. Runs on the 50 MHz system clock; the strobe comes from `frqdivmod` (DIV=1042).

## Interface
- `SAMPLE_W`, 16: width of signed audio sample in/out.
- `ENV_W`, 24: width of unsigned envelope word; also the number of multiply iterations.

- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  reset. Synchronous, active-low: sampled on the rising edge of `clk`; state is reset while low.
- `low_clk`  in  1  sample strobe; one-`clk`-wide pulse at 48 kHz.
- `sample_in`  in  SAMPLE_W  signed two's-complement audio sample from the oscillator.
- `env_in`  in  ENV_W  unsigned envelope level (0 = silent, 2^ENV_W−1 = full).
- `sample_out`  out  SAMPLE_W  signed, amplitude-scaled sample; held between updates.
- `sample_valid`  out  1  one-cycle pulse when `sample_out` updates.
- `busy`  out  1  high while a multiply is in progress.
- `overrun`  out  1  sticky; set when a strobe arrives while busy. Cleared only by reset.

## Operation
- FSM states: IDLE, MUL, DONE.
- IDLE:
  - `busy`=0.
  - On `low_clk`=1: latch `sample_in` into the multiplicand register (sign-extended to SAMPLE_W+ENV_W).
  - Latch the effective envelope into the multiplier register, clear the accumulator and bit counter, go to MUL.
- MUL:
  - Performs one iteration per cycle for ENV_W cycles.
  - If multiplier LSB=1, add the multiplicand to the accumulator.
  - Shift the multiplicand left 1 and the multiplier right 1, then increment the counter.
  - After iteration ENV_W−1, go to DONE.
- DONE:
  - `sample_out` ← (acc + 2^(ENV_W−1)) >>> ENV_W, truncated to SAMPLE_W. This is round-half-up, arithmetic shift.
  - Pulse `sample_valid`, then return to IDLE.
- Arithmetic:
  - Signed × unsigned product, held in a SAMPLE_W+ENV_W accumulator.
  - |result| ≤ |sample_in| for all inputs, so no saturation logic is needed.
  - Full-scale cases: −2^(SAMPLE_W−1) at max env gives −2^(SAMPLE_W−1); 2^(SAMPLE_W−1)−1 at max env gives 2^(SAMPLE_W−1)−1.
- A `low_clk` arriving in MUL or DONE is ignored and sets `overrun`. The in-flight multiply completes unaffected.
- `sample_in` and `env_in` may change freely after the strobe cycle; only the latched values are used.

## Timing
- Reset (`rst`=0 at a rising edge): state=IDLE; `sample_out`=0, `sample_valid`=0, `busy`=0, `overrun`=0; accumulator, counter and smoothing register cleared.
- Reset mid-multiply aborts the multiply: no `sample_valid`, and `sample_out` is forced to 0.
- Sequence for a strobe sampled at edge k:
  - `busy`=1 from after edge k.
  - Iterations occur at edges k+1 … k+ENV_W.
  - `sample_out` and `sample_valid`=1 update at edge k+ENV_W+1.
  - `busy`=0 and `sample_valid`=0 after edge k+ENV_W+2.
- Latency is ENV_W+1 clocks (25 at default), well inside the 1042-clock strobe period.
- A strobe at edge k+ENV_W+2 or later is accepted normally. Back-to-back processing has no gaps.
- `low_clk` held high for multiple cycles: the first cycle starts a multiply; the following cycles count as overrun.

## Configuration
- `VCA_ENV_SMOOTH_EN` defined: the effective envelope is a one-pole smoothed copy `env_s`, updated once per accepted strobe before latching.
  - Update rule: `env_s` ← `env_s` + ((`env_in` − `env_s`) >>> 4), using signed ENV_W+1 difference arithmetic.
  - `env_s` resets to 0.
  - This removes zipper noise from `adsr` steps. It adds no extra clock latency, because the update happens in the strobe cycle.
- `VCA_ENV_SMOOTH_EN` undefined: `env_in` is latched directly. No `env_s` register is built.

## Test plan
- Reset and hold: `rst`=0 for 4 cycles, then 1 with no strobe → all outputs 0; `busy`=0 for 100 cycles.
- Unity/zero/half gain, sample_in=1000:
  - env=2^24−1 → `sample_out`=1000.
  - env=0 → 0.
  - env=2^23 → 500.
  - sample_in=−1000, env=2^23 → −500.
  - Each case: `sample_valid` exactly 25 clocks after the strobe cycle, one cycle wide.
- Extremes and rounding (smoothing off):
  - −32768 at max env → −32768.
  - 32767 at max env → 32767.
  - 1 at env 2^23 → 1.
  - −1 at env 2^23 → 0.
- Overrun: second strobe 10 cycles after the first → `overrun`=1 and stays set; the first result is correct; no second `sample_valid`.
- Reset mid-operation: `rst`=0 at strobe+12 → no `sample_valid`, `sample_out`=0. Next strobe after release gives a correct result.
- With `VCA_ENV_SMOOTH_EN`, env_in stepped 0→0xFFFFFF, sample_in=16384:
  - Successive outputs follow `env_s` = 0x0FFFFF, 0x1EFFFF, … (monotonic rise).
  - Outputs converge to 16384 within 200 strobes.
  - Driven by `frqdivmod`-style strobes at a 1042-clock period.
